// File: rtl/snake_step_sched.sv
// Snake movement scheduler: per-level step period and evaluate -> check -> commit move sequencing.
// Build option STEP_SCHED_PAUSE_EN adds a pause input that freezes the period counter.
module snake_step_sched #(
  parameter int unsigned P1        = 25000000,
  parameter int unsigned P2        = 18000000,
  parameter int unsigned P3        = 12000000,
  parameter int unsigned CNT_W     = 28,
  parameter int unsigned CHECK_LAT = 2,
  parameter int unsigned INIT_LEN  = 3,
  parameter int unsigned MAX_LEN   = 20,
  parameter logic [2:0]  MAIN_START = 3'd1,
  parameter logic [2:0]  MAIN_GAME1 = 3'd2,
  parameter logic [2:0]  MAIN_GAME2 = 3'd3,
  parameter logic [2:0]  MAIN_GAME3 = 3'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic       accelerate,
  input  logic       poisoned,
`ifdef STEP_SCHED_PAUSE_EN
  input  logic       pause,
`endif
  input  logic       ate,
  input  logic       hit_wall,
  input  logic       hit_body,
  output logic       eval_req,
  output logic       snake_clock,
  output logic       grow,
  output logic       death,
  output logic       win,
  output logic [4:0] snake_len,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Handshake: eval_req and snake_clock are one-cycle strobes with no back-pressure;
  // ate/hit_wall/hit_body are taken as valid on the edge CHECK_LAT cycles after eval_req.

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_CHECK, S_COMMIT} sched_state_t;

  localparam logic [CNT_W-1:0] BASE1    = CNT_W'(P1);
  localparam logic [CNT_W-1:0] BASE2    = CNT_W'(P2);
  localparam logic [CNT_W-1:0] BASE3    = CNT_W'(P3);
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(CHECK_LAT - 1);
  localparam logic [4:0]       INIT_L   = 5'(INIT_LEN);
  localparam logic [4:0]       MAX_L    = 5'(MAX_LEN);

  sched_state_t     cur, nxt;
  logic [CNT_W-1:0] counter, counter_nxt;
  logic [CNT_W-1:0] base, period;
  logic             play, hold, ate_q, ate_nxt;
  logic             eval_nxt, sclk_nxt, grow_nxt, win_nxt, death_nxt, busy_nxt;
  logic [4:0]       len_nxt;

`ifdef STEP_SCHED_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign play = (state == MAIN_GAME1) || (state == MAIN_GAME2) || (state == MAIN_GAME3);
  assign dbg_state = cur;

  always_comb begin
    base = BASE3;
    if (state == MAIN_GAME1)      base = BASE1;
    else if (state == MAIN_GAME2) base = BASE2;
    case ({accelerate, poisoned})
      2'b10:   period = base >> 1;
      2'b01:   period = base << 1;
      default: period = base;
    endcase
  end

  // The counter keeps running from eval_req through check and commit, so the
  // step period is measured eval-to-eval rather than commit-to-eval.
  always_comb begin
    nxt         = cur;
    counter_nxt = counter;
    eval_nxt    = 1'b0;
    sclk_nxt    = 1'b0;
    grow_nxt    = 1'b0;
    win_nxt     = 1'b0;
    ate_nxt     = ate_q;
    len_nxt     = snake_len;
    death_nxt   = death;
    if (state == MAIN_START) begin
      len_nxt   = INIT_L;
      death_nxt = 1'b0;
    end
    if (!play) begin
      nxt         = S_IDLE;
      counter_nxt = '0;
    end else begin
      case (cur)
        S_IDLE: begin
          counter_nxt = '0;
          if (!death) nxt = S_COUNT;
        end
        S_COUNT: begin
          if (hold) begin
            counter_nxt = counter;
          end else if (counter >= period - CNT_W'(1)) begin
            counter_nxt = '0;
            eval_nxt    = 1'b1;
            nxt         = S_CHECK;
          end else begin
            counter_nxt = counter + CNT_W'(1);
          end
        end
        S_CHECK: begin
          counter_nxt = counter + CNT_W'(1);
          if (counter == SAMPLE_AT) begin
            if (hit_wall || hit_body) begin
              death_nxt   = 1'b1;
              counter_nxt = '0;
              nxt         = S_IDLE;
            end else begin
              ate_nxt = ate;
              nxt     = S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          counter_nxt = counter + CNT_W'(1);
          sclk_nxt    = 1'b1;
          grow_nxt    = ate_q;
          if (ate_q && (snake_len < MAX_L)) begin
            len_nxt = snake_len + 5'd1;
            win_nxt = ((snake_len + 5'd1) == MAX_L);
          end
          nxt = S_COUNT;
        end
        default: nxt = S_IDLE;
      endcase
    end
    busy_nxt = (nxt == S_CHECK) || (nxt == S_COMMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur         <= S_IDLE;
      counter     <= '0;
      ate_q       <= 1'b0;
      eval_req    <= 1'b0;
      snake_clock <= 1'b0;
      grow        <= 1'b0;
      death       <= 1'b0;
      win         <= 1'b0;
      snake_len   <= INIT_L;
      busy        <= 1'b0;
    end else begin
      cur         <= nxt;
      counter     <= counter_nxt;
      ate_q       <= ate_nxt;
      eval_req    <= eval_nxt;
      snake_clock <= sclk_nxt;
      grow        <= grow_nxt;
      death       <= death_nxt;
      win         <= win_nxt;
      snake_len   <= len_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule
